// File: rtl/decode_pkg.sv
// Shared types and constants for the decode stage.
// The control bundle travels from the control unit through the decode
// register into execute; immsrc selects the immediate format.
package decode_pkg;

  // Immediate format selectors carried in ctrl_t.immsrc.
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef struct packed {
    logic       regwrite;
    logic [1:0] resultsrc;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic [2:0] alucontrol;
    logic       alusrc;
    logic [1:0] immsrc;
  } ctrl_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: assembles the I/S/B/J immediate from
// the instruction word and sign-extends it from bit 31 to XLEN.
import decode_pkg::*;

module imm_gen #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [1:0]      immsrc,
  output logic [XLEN-1:0] imm
);

  logic [31:0] w_imm32;
  // The opcode field never contributes to an immediate.
  logic        w_unused_opcode;

  assign w_unused_opcode = ^instr[6:0];

  // Select the 32-bit immediate for the requested format.
  always_comb begin
    w_imm32 = '0;
    unique case (immsrc)
      IMM_I: w_imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S: w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: w_imm32 = {{19{instr[31]}}, instr[31], instr[7],
                        instr[30:25], instr[11:8], 1'b0};
      IMM_J: w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                        instr[20], instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  // Widen to XLEN only when the datapath is wider than 32 bits.
  generate
    if (XLEN > 32) begin : g_sext
      assign imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_direct
      assign imm = w_imm32[XLEN-1:0];
    end
  endgenerate

endmodule

// File: rtl/decode_stage_hs.sv
// Decode pipeline stage with valid/ready handshake.
// Holds an internal register file, captures operands, register addresses,
// immediate, PCs and control into an output register, and counts stall
// cycles with a saturating counter.
// Optional build macro: DECODE_WB_BYPASS_EN -- forwards writeback data into
// the operand registers at load time and refreshes held operands while
// the stage is stalled.
import decode_pkg::*;

module decode_stage_hs #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              instr,
  input  logic [XLEN-1:0]          pc,
  input  logic [XLEN-1:0]          pc_plus4,
  input  ctrl_t                    ctrl_in,
  input  logic                     wb_we,
  input  logic [$clog2(NREGS)-1:0] wb_rd,
  input  logic [XLEN-1:0]          wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output ctrl_t                    ctrl_out,
  output logic [XLEN-1:0]          rd1,
  output logic [XLEN-1:0]          rd2,
  output logic [$clog2(NREGS)-1:0] rs1,
  output logic [$clog2(NREGS)-1:0] rs2,
  output logic [$clog2(NREGS)-1:0] rd,
  output logic [XLEN-1:0]          imm,
  output logic [XLEN-1:0]          pc_out,
  output logic [XLEN-1:0]          pc_plus4_out,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int RA = $clog2(NREGS);

  // Register file; entry 0 is never written and is also masked on read.
  logic [XLEN-1:0] r_regs [NREGS];

  // Output (execute-side) registers.
  logic             r_out_valid;
  ctrl_t            r_ctrl;
  logic [XLEN-1:0]  r_rd1;
  logic [XLEN-1:0]  r_rd2;
  logic [RA-1:0]    r_rs1;
  logic [RA-1:0]    r_rs2;
  logic [RA-1:0]    r_rd;
  logic [XLEN-1:0]  r_imm;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_pc_plus4;
  logic [CNT_W-1:0] r_stall_cnt;

  // Combinational decode of the incoming instruction.
  logic [RA-1:0]    w_rs1;
  logic [RA-1:0]    w_rs2;
  logic [RA-1:0]    w_rd;
  logic [XLEN-1:0]  w_rf1;
  logic [XLEN-1:0]  w_rf2;
  logic [XLEN-1:0]  w_op1;
  logic [XLEN-1:0]  w_op2;
  logic [XLEN-1:0]  w_imm;
  logic             w_in_ready;
  logic             w_load;
  logic             w_stall;
  logic             w_wb_act;

  // Address fields are truncated to the register-address width.
  assign w_rs1 = instr[15 +: RA];
  assign w_rs2 = instr[20 +: RA];
  assign w_rd  = instr[7 +: RA];

  // Handshake: accept whenever the output slot is empty or draining.
  assign w_in_ready = !r_out_valid || out_ready;
  assign w_load     = in_valid && w_in_ready && !flush;
  assign w_stall    = r_out_valid && !out_ready;
  assign w_wb_act   = wb_we && (wb_rd != '0);

  // Read ports return the value stored before this edge's writeback.
  assign w_rf1 = (w_rs1 == '0) ? '0 : r_regs[w_rs1];
  assign w_rf2 = (w_rs2 == '0) ? '0 : r_regs[w_rs2];

`ifdef DECODE_WB_BYPASS_EN
  // Same-cycle writeback to a source register wins over the stale copy.
  assign w_op1 = (w_wb_act && (wb_rd == w_rs1)) ? wb_data : w_rf1;
  assign w_op2 = (w_wb_act && (wb_rd == w_rs2)) ? wb_data : w_rf2;
`else
  // Operands are the pre-write values; hazards are handled upstream.
  assign w_op1 = w_rf1;
  assign w_op2 = w_rf2;
`endif

  imm_gen #(
    .XLEN(XLEN)
  ) u_imm_gen (
    .instr (instr),
    .immsrc(ctrl_in.immsrc),
    .imm   (w_imm)
  );

  // Register file write; reset clears every entry and blocks the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_act) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  // Output-valid flag: flush beats load, load beats drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Non-operand payload captures on load and otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl     <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_imm      <= '0;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
    end else if (w_load) begin
      r_ctrl     <= ctrl_in;
      r_rs1      <= w_rs1;
      r_rs2      <= w_rs2;
      r_rd       <= w_rd;
      r_imm      <= w_imm;
      r_pc       <= pc;
      r_pc_plus4 <= pc_plus4;
    end
  end

  // Operand registers capture on load; with bypass they also track
  // writebacks to the held source registers while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd1 <= '0;
      r_rd2 <= '0;
    end else if (w_load) begin
      r_rd1 <= w_op1;
      r_rd2 <= w_op2;
    end else if (w_stall) begin
`ifdef DECODE_WB_BYPASS_EN
      if (w_wb_act && (wb_rd == r_rs1)) begin
        r_rd1 <= wb_data;
      end
      if (w_wb_act && (wb_rd == r_rs2)) begin
        r_rd2 <= wb_data;
      end
`else
      r_rd1 <= r_rd1;
      r_rd2 <= r_rd2;
`endif
    end
  end

  // Saturating count of cycles where execute refused a valid payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = r_out_valid;
  assign ctrl_out     = r_ctrl;
  assign rd1          = r_rd1;
  assign rd2          = r_rd2;
  assign rs1          = r_rs1;
  assign rs2          = r_rs2;
  assign rd           = r_rd;
  assign imm          = r_imm;
  assign pc_out       = r_pc;
  assign pc_plus4_out = r_pc_plus4;
  assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_decode_stage_hs.sv
// Directed bench for decode_stage_hs: a vector table for single-cycle
// behaviour plus hand sequences for stall, bypass and reset-in-stall.
// A second instance with a 3-bit stall counter checks saturation.
import decode_pkg::*;

module tb_decode_stage_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  ctrl_t       ctrl_in;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  ctrl_t       ctrl_out;
  logic [31:0] rd1, rd2, imm, pc_out, pc_plus4_out;
  logic [4:0]  rs1, rs2, rd;
  logic [15:0] stall_cnt;

  // Outputs of the small-counter instance.
  logic        s_in_ready, s_out_valid;
  ctrl_t       s_ctrl_out;
  logic [31:0] s_rd1, s_rd2, s_imm, s_pc_out, s_pc_plus4_out;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [2:0]  s_stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage_hs #(.XLEN(32), .NREGS(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
    .ctrl_in(ctrl_in), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .ctrl_out(ctrl_out),
    .rd1(rd1), .rd2(rd2), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .pc_out(pc_out), .pc_plus4_out(pc_plus4_out), .stall_cnt(stall_cnt)
  );

  decode_stage_hs #(.XLEN(32), .NREGS(32), .CNT_W(3)) dut_small (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_ready(s_in_ready), .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
    .ctrl_in(ctrl_in), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .ctrl_out(s_ctrl_out),
    .rd1(s_rd1), .rd2(s_rd2), .rs1(s_rs1), .rs2(s_rs2), .rd(s_rd),
    .imm(s_imm), .pc_out(s_pc_out), .pc_plus4_out(s_pc_plus4_out),
    .stall_cnt(s_stall_cnt)
  );

  typedef struct {
    logic        in_valid, out_ready, flush, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, instr;
    logic [1:0]  immsrc;
    logic [31:0] pc;
    logic        exp_in_ready, exp_valid;
    logic [31:0] exp_rd1, exp_rd2, exp_imm, exp_pc;
    logic [4:0]  exp_rs1, exp_rd;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(
    input logic iv, input logic ordy, input logic fl, input logic we,
    input logic [4:0] wrd, input logic [31:0] wdat, input logic [31:0] ins,
    input logic [1:0] isrc, input logic [31:0] p,
    input logic e_inr, input logic e_v, input logic [31:0] e_rd1,
    input logic [31:0] e_rd2, input logic [31:0] e_imm, input logic [31:0] e_pc,
    input logic [4:0] e_rs1, input logic [4:0] e_rd);
    vec_t v;
    v.in_valid = iv; v.out_ready = ordy; v.flush = fl; v.wb_we = we;
    v.wb_rd = wrd; v.wb_data = wdat; v.instr = ins; v.immsrc = isrc; v.pc = p;
    v.exp_in_ready = e_inr; v.exp_valid = e_v; v.exp_rd1 = e_rd1;
    v.exp_rd2 = e_rd2; v.exp_imm = e_imm; v.exp_pc = e_pc;
    v.exp_rs1 = e_rs1; v.exp_rd = e_rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic ordy,
                       input logic fl, input logic we, input logic [4:0] wrd,
                       input logic [31:0] wdat, input logic [31:0] ins,
                       input logic [1:0] isrc, input logic [31:0] p);
    rst = r; in_valid = iv; out_ready = ordy; flush = fl; wb_we = we;
    wb_rd = wrd; wb_data = wdat; instr = ins; pc = p; pc_plus4 = p + 32'd4;
    ctrl_in = ctrl_t'({10'b1100101011, isrc});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_v;

    //          iv ordy fl we rd  wdata      instr         isrc pc       inr v  rd1        rd2        imm           pc       rs1 rd
    vecs[0] = mk(0, 1, 0, 1, 5, 32'h1234, 32'h0,        2'd0, 32'h0,   1, 0, 32'h0,     32'h0,     32'h0,        32'h0,   0,  0);
    vecs[1] = mk(1, 1, 0, 0, 0, 32'h0,    32'hFFF28093, 2'd0, 32'h100, 1, 1, 32'h1234,  32'h0,     32'hFFFFFFFF, 32'h100, 5,  1);
    vecs[2] = mk(0, 1, 0, 0, 0, 32'h0,    32'h0,        2'd0, 32'h0,   1, 0, 32'h1234,  32'h0,     32'hFFFFFFFF, 32'h100, 5,  1);
    vecs[3] = mk(1, 1, 0, 0, 0, 32'h0,    32'hFE62AE23, 2'd1, 32'h104, 1, 1, 32'h1234,  32'h0,     32'hFFFFFFFC, 32'h104, 5,  28);
    vecs[4] = mk(1, 1, 0, 0, 0, 32'h0,    32'h00628863, 2'd2, 32'h108, 1, 1, 32'h1234,  32'h0,     32'h10,       32'h108, 5,  16);
    vecs[5] = mk(1, 1, 0, 0, 0, 32'h0,    32'hFF9FF0EF, 2'd3, 32'h10C, 1, 1, 32'h0,     32'h0,     32'hFFFFFFF8, 32'h10C, 31, 1);
    vecs[6] = mk(1, 1, 1, 0, 0, 32'h0,    32'h00500133, 2'd0, 32'h200, 1, 0, 32'h0,     32'h0,     32'hFFFFFFF8, 32'h10C, 31, 1);
    vecs[7] = mk(0, 1, 0, 1, 0, 32'hDEAD, 32'h0,        2'd0, 32'h0,   1, 0, 32'h0,     32'h0,     32'hFFFFFFF8, 32'h10C, 31, 1);
    vecs[8] = mk(1, 1, 0, 0, 0, 32'h0,    32'h00500133, 2'd0, 32'h110, 1, 1, 32'h0,     32'h1234,  32'h5,        32'h110, 0,  2);

    // Reset with a writeback and load pending; reset must win.
    drive(1, 1, 1, 0, 1, 5'd3, 32'hFFFF, 32'h00018093, 2'd0, 32'h50);
    repeat (2) @(posedge clk);
    #1;
    $display("reset: out_valid=%0b stall_cnt=%0d", out_valid, stall_cnt);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_rd1", 64'(rd1), 64'd0);
    chk("rst_imm", 64'(imm), 64'd0);
    chk("rst_pc_out", 64'(pc_out), 64'd0);
    chk("rst_ctrl", {52'd0, ctrl_out}, 64'd0);

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(0, vecs[i].in_valid, vecs[i].out_ready, vecs[i].flush, vecs[i].wb_we,
            vecs[i].wb_rd, vecs[i].wb_data, vecs[i].instr, vecs[i].immsrc, vecs[i].pc);
      #1;
      chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_in_ready));
      @(posedge clk);
      #1;
      $display("vec %0d: instr=%08h valid=%0b rd1=%0h rd2=%0h imm=%0h pc=%0h rs1=%0d rd=%0d",
               i, vecs[i].instr, out_valid, rd1, rd2, imm, pc_out, rs1, rd);
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("v%0d_rd1", i), 64'(rd1), 64'(vecs[i].exp_rd1));
      chk($sformatf("v%0d_rd2", i), 64'(rd2), 64'(vecs[i].exp_rd2));
      chk($sformatf("v%0d_imm", i), 64'(imm), 64'(vecs[i].exp_imm));
      chk($sformatf("v%0d_pc", i), 64'(pc_out), 64'(vecs[i].exp_pc));
      chk($sformatf("v%0d_rs1", i), 64'(rs1), 64'(vecs[i].exp_rs1));
      chk($sformatf("v%0d_rd", i), 64'(rd), 64'(vecs[i].exp_rd));
    end
    chk("ctrl_after_load", {52'd0, ctrl_out}, 64'hCAC);
    chk("pc_plus4_after_load", 64'(pc_plus4_out), 64'h114);
    chk("rs2_after_load", 64'(rs2), 64'd5);

    // Ten stall cycles with a new instruction offered; payload must hold.
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      drive(0, 1, 0, 0, 0, 5'd0, 32'h0, 32'h12345678, 2'd1, 32'h300);
      #1;
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      $display("stall %0d: valid=%0b stall_cnt=%0d small=%0d rd2=%0h", c, out_valid,
               stall_cnt, s_stall_cnt, rd2);
      if (c == 5) begin
        chk("stall5_cnt", 64'(stall_cnt), 64'd5);
        chk("stall5_valid", 64'(out_valid), 64'd1);
        chk("stall5_rd2", 64'(rd2), 64'h1234);
        chk("stall5_imm", 64'(imm), 64'h5);
        chk("stall5_pc", 64'(pc_out), 64'h110);
      end
    end
    chk("stall10_cnt", 64'(stall_cnt), 64'd10);
    chk("stall10_small_sat", 64'(s_stall_cnt), 64'd7);

    // Writeback to the held rs2 while stalled.
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 5'd5, 32'hBB, 32'h0, 2'd0, 32'h0);
    @(posedge clk);
    #1;
`ifdef DECODE_WB_BYPASS_EN
    exp_v = 32'hBB;
`else
    exp_v = 32'h1234;
`endif
    $display("stall wb x5: rd2=%0h", rd2);
    chk("stall_wb_rd2", 64'(rd2), 64'(exp_v));
    chk("stall11_cnt", 64'(stall_cnt), 64'd11);

    // Load instr rs2=7 while x7 is written in the same cycle.
    @(negedge clk);
    drive(0, 1, 1, 0, 1, 5'd7, 32'hAA, 32'h007001B3, 2'd0, 32'h400);
    #1;
    chk("drain_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
`ifdef DECODE_WB_BYPASS_EN
    exp_v = 32'hAA;
`else
    exp_v = 32'h0;
`endif
    $display("load wb x7: valid=%0b rs2=%0d rd2=%0h", out_valid, rs2, rd2);
    chk("load_wb_valid", 64'(out_valid), 64'd1);
    chk("load_wb_rs2", 64'(rs2), 64'd7);
    chk("load_wb_rd2", 64'(rd2), 64'(exp_v));
    chk("load_wb_cnt", 64'(stall_cnt), 64'd11);

    // Two stall cycles, then reset with a writeback pending.
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 2'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_cnt", 64'(stall_cnt), 64'd13);
    @(negedge clk);
    drive(1, 1, 0, 0, 1, 5'd9, 32'h55, 32'h00548233, 2'd0, 32'h500);
    @(posedge clk);
    #1;
    $display("reset in stall: valid=%0b stall_cnt=%0d", out_valid, stall_cnt);
    chk("rst_stall_valid", 64'(out_valid), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_stall_small_cnt", 64'(s_stall_cnt), 64'd0);
    chk("rst_stall_rd2", 64'(rd2), 64'd0);
    chk("rst_stall_pc", 64'(pc_out), 64'd0);

    @(negedge clk);
    drive(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 2'd0, 32'h0);
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    drive(0, 1, 0, 0, 0, 5'd0, 32'h0, 32'h00548233, 2'd0, 32'h600);
    @(posedge clk);
    #1;
    $display("post reset load: valid=%0b rs1=%0d rd1=%0h rd2=%0h", out_valid, rs1, rd1, rd2);
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_rs1", 64'(rs1), 64'd9);
    chk("post_rst_x9", 64'(rd1), 64'd0);
    chk("post_rst_x5", 64'(rd2), 64'd0);
    chk("post_rst_pc", 64'(pc_out), 64'h600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
